// File: rtl/spart_pkg.sv
// Shared types and constants for the SPART bus arbiter: FSM states, ioaddr map, iorw encoding.
package spart_pkg;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_WAIT   = 2'd1,
    S_ACCESS = 2'd2,
    S_DONE   = 2'd3
  } state_t;

  localparam logic [1:0] ADDR_BUF  = 2'b00;
  localparam logic [1:0] ADDR_STAT = 2'b01;
  localparam logic [1:0] ADDR_DBL  = 2'b10;
  localparam logic [1:0] ADDR_DBH  = 2'b11;

  localparam logic IORW_READ  = 1'b1;
  localparam logic IORW_WRITE = 1'b0;

  // Buffer accesses wait for the SPART; status and divisor registers are always ready.
  function automatic logic access_ready(input logic rw, input logic [1:0] addr,
                                        input logic tbr, input logic rda);
    if (addr != ADDR_BUF) return 1'b1;
    return (rw == IORW_READ) ? rda : tbr;
  endfunction

endpackage

// File: rtl/spart_bus_arbiter_if.sv
// Requester-side bus of the SPART arbiter. req is held high until ack; ack is a one-cycle
// pulse to the owner; gnt marks ownership from WAIT through DONE; rdata/err are valid with ack.
interface spart_bus_arbiter_if #(parameter int NUM_REQ = 2);
  logic [NUM_REQ-1:0]   req;
  logic [NUM_REQ-1:0]   req_rw;
  logic [2*NUM_REQ-1:0] req_addr;
  logic [8*NUM_REQ-1:0] req_wdata;
  logic [NUM_REQ-1:0]   gnt;
  logic [NUM_REQ-1:0]   ack;
  logic                 err;
  logic [7:0]           rdata;

  modport master (output req, req_rw, req_addr, req_wdata,
                  input  gnt, ack, err, rdata);

  modport slave  (input  req, req_rw, req_addr, req_wdata,
                  output gnt, ack, err, rdata);
endinterface

// File: rtl/spart_rr_picker.sv
// Round-robin picker: first set request searching upward from ptr+1, wrapping at NUM_REQ.
module spart_rr_picker #(
  parameter int NUM_REQ = 2,
  parameter int IDX_W   = 1
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDX_W-1:0]   ptr,
  output logic [NUM_REQ-1:0] pick_oh,
  output logic [IDX_W-1:0]   pick_idx,
  output logic               any
);

  int               cand;
  logic [IDX_W-1:0] ci;

  always_comb begin
    pick_oh  = '0;
    pick_idx = '0;
    any      = 1'b0;
    cand     = 0;
    ci       = '0;
    for (int off = 1; off <= NUM_REQ; off++) begin
      cand = (int'(ptr) + off) % NUM_REQ;
      ci   = IDX_W'(cand);
      if (!any && req[ci]) begin
        any          = 1'b1;
        pick_oh[ci]  = 1'b1;
        pick_idx     = ci;
      end
    end
  end

endmodule

// File: rtl/spart_bus_arbiter.sv
// Round-robin arbiter sharing one SPART processor bus between NUM_REQ requesters.
// Optional WAIT-state timeout is enabled with `define SPART_ARB_TIMEOUT_EN.
module spart_bus_arbiter
  import spart_pkg::*;
#(
  parameter int NUM_REQ     = 2,
  parameter int TIMEOUT_CYC = 1024
) (
  input  logic                clk,
  input  logic                rst,
  spart_bus_arbiter_if.slave  bus,
  output logic                iocs,
  output logic                iorw,
  output logic [1:0]          ioaddr,
  input  logic                rda,
  input  logic                tbr,
  inout  wire  [7:0]          databus,
  output state_t              dbg_state
);

  localparam int IDX_W = $clog2(NUM_REQ);

  if (NUM_REQ < 2) begin : g_bad_num_req
    $error("spart_bus_arbiter: NUM_REQ must be at least 2");
  end
  if (TIMEOUT_CYC < 1) begin : g_bad_timeout
    $error("spart_bus_arbiter: TIMEOUT_CYC must be at least 1");
  end

  state_t             state;
  logic [IDX_W-1:0]   ptr;
  logic [IDX_W-1:0]   idx_q;
  logic               rw_q;
  logic [1:0]         addr_q;
  logic [7:0]         wdata_q;
  logic [NUM_REQ-1:0] pick_oh;
  logic [IDX_W-1:0]   pick_idx;
  logic               pick_any;
  logic               ready;

`ifdef SPART_ARB_TIMEOUT_EN
  localparam int TMO_W = $clog2(TIMEOUT_CYC) + 1;
  logic [TMO_W-1:0] tmo_cnt;
`endif

  spart_rr_picker #(.NUM_REQ(NUM_REQ), .IDX_W(IDX_W)) u_picker (
    .req      (bus.req),
    .ptr      (ptr),
    .pick_oh  (pick_oh),
    .pick_idx (pick_idx),
    .any      (pick_any)
  );

  assign ready     = access_ready(rw_q, addr_q, tbr, rda);
  assign dbg_state = state;
  // Bus outputs are registered, so the write driver is glitch-free and releases on reset.
  assign databus   = (iocs && (iorw == IORW_WRITE)) ? wdata_q : 8'hzz;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= S_IDLE;
      ptr       <= IDX_W'(NUM_REQ - 1);
      idx_q     <= '0;
      rw_q      <= IORW_READ;
      addr_q    <= ADDR_BUF;
      wdata_q   <= '0;
      bus.gnt   <= '0;
      bus.ack   <= '0;
      bus.err   <= 1'b0;
      bus.rdata <= '0;
      iocs      <= 1'b0;
      iorw      <= IORW_READ;
      ioaddr    <= ADDR_BUF;
`ifdef SPART_ARB_TIMEOUT_EN
      tmo_cnt   <= '0;
`endif
    end else begin
      bus.ack <= '0;
      bus.err <= 1'b0;
      iocs    <= 1'b0;
      iorw    <= IORW_READ;
      ioaddr  <= ADDR_BUF;
      case (state)
        S_IDLE: begin
          if (pick_any) begin
            idx_q   <= pick_idx;
            rw_q    <= bus.req_rw[pick_idx];
            addr_q  <= bus.req_addr[2*pick_idx +: 2];
            wdata_q <= bus.req_wdata[8*pick_idx +: 8];
            bus.gnt <= pick_oh;
            state   <= S_WAIT;
`ifdef SPART_ARB_TIMEOUT_EN
            tmo_cnt <= '0;
`endif
          end
        end
        S_WAIT: begin
          if (ready) begin
            iocs   <= 1'b1;
            iorw   <= rw_q;
            ioaddr <= addr_q;
            state  <= S_ACCESS;
          end
`ifdef SPART_ARB_TIMEOUT_EN
          else if (tmo_cnt == TMO_W'(TIMEOUT_CYC - 1)) begin
            bus.ack <= bus.gnt;
            bus.err <= 1'b1;
            state   <= S_DONE;
          end else begin
            tmo_cnt <= tmo_cnt + 1'b1;
          end
`endif
        end
        S_ACCESS: begin
          if (rw_q == IORW_READ) bus.rdata <= databus;
          bus.ack <= bus.gnt;
          state   <= S_DONE;
        end
        S_DONE: begin
          bus.gnt <= '0;
          ptr     <= idx_q;
          state   <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
